// File: rtl/sync_pkg.sv
// Shared definitions for the synchronizer family: default depths, filter
// decision encoding and a counter-width helper.
package sync_pkg;

  localparam int unsigned SYNC_STAGES_DEFAULT = 2;
  localparam int unsigned SYNC_FILTER_DEFAULT = 4;

  typedef enum logic [1:0] {
    FILT_HOLD   = 2'd0,
    FILT_ACCEPT = 2'd1,
    FILT_COUNT  = 2'd2
  } filt_act_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// One channel: STAGES-deep synchronizer, persistence filter on the synced
// level, and registered rise/fall strobes.
module sync_filter_chan
  import sync_pkg::*;
#(
  parameter int unsigned STAGES        = SYNC_STAGES_DEFAULT,
  parameter int unsigned FILTER_CYCLES = SYNC_FILTER_DEFAULT,
  parameter logic        RST_BIT       = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic data_in,
  output logic data_out,
  output logic rise,
  output logic fall,
  output logic update
);

  localparam int unsigned CW = clog2_min1(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

  logic [STAGES-1:0] stage;
  logic [CW-1:0]     cnt;
  logic              s;
  filt_act_e         act;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage <= {STAGES{RST_BIT}};
    end else begin
      stage <= {stage[STAGES-2:0], data_in};
    end
  end

  assign s = stage[STAGES-1];

  // Agreement with data_out always wins, so any reversion clears the count.
  always_comb begin
    act = FILT_COUNT;
    if (s == data_out) begin
      act = FILT_HOLD;
    end else if (cnt == CNT_MAX) begin
      act = FILT_ACCEPT;
    end
  end

  assign update = (act == FILT_ACCEPT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      data_out <= RST_BIT;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      rise <= update & s;
      fall <= update & ~s;
      unique case (act)
        FILT_HOLD: cnt <= '0;
        FILT_ACCEPT: begin
          data_out <= s;
          cnt      <= '0;
        end
        default: cnt <= cnt + 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/sync_filter_bank.sv
// WIDTH independent synchronize-and-filter channels with a registered
// any-change strobe covering all rise/fall events.
module sync_filter_bank
  import sync_pkg::*;
#(
  parameter int unsigned      WIDTH         = 8,
  parameter int unsigned      STAGES        = SYNC_STAGES_DEFAULT,
  parameter int unsigned      FILTER_CYCLES = SYNC_FILTER_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_change
);

  logic [WIDTH-1:0] update;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sync_filter_chan #(
      .STAGES       (STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .RST_BIT      (RESET_VAL[i])
    ) u_chan (
      .clock   (clock),
      .reset_n (reset_n),
      .data_in (data_in[i]),
      .data_out(data_out[i]),
      .rise    (rise[i]),
      .fall    (fall[i]),
      .update  (update[i])
    );
  end

  // Registered from the pre-flop accept terms so it lines up with rise/fall.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      any_change <= 1'b0;
    end else begin
      any_change <= |update;
    end
  end

endmodule

// File: tb/tb_sync_filter_bank.sv
// Directed bench for sync_filter_bank: reset, latency, glitch rejection,
// mixed channels, reset mid-filter, and fast chatter with no filtering.
module tb_sync_filter_bank;

  logic       clock;
  logic       reset_n;
  logic [3:0] data_in;
  logic [3:0] data_out, rise, fall;
  logic       any_change;
  logic [3:0] din2;
  logic [3:0] dout2, rise2, fall2;
  logic       any2;

  int checks = 0;
  int errors = 0;

  sync_filter_bank #(
    .WIDTH(4), .STAGES(2), .FILTER_CYCLES(3), .RESET_VAL(4'b0100)
  ) u_dut (
    .clock(clock), .reset_n(reset_n), .data_in(data_in),
    .data_out(data_out), .rise(rise), .fall(fall), .any_change(any_change)
  );

  sync_filter_bank #(
    .WIDTH(4), .STAGES(3), .FILTER_CYCLES(1), .RESET_VAL(4'b0100)
  ) u_chat (
    .clock(clock), .reset_n(reset_n), .data_in(din2),
    .data_out(dout2), .rise(rise2), .fall(fall2), .any_change(any2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] val);
    reset_n = 1'b0;
    data_in = val;
    tick();
    tick();
    reset_n = 1'b1;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    logic [3:0] exp_do, exp_r;
    reset_n = 1'b0;
    data_in = 4'hF;
    din2    = 4'b0100;
    tick();
    tick();
    checks++;
    if (data_out !== 4'b0100 || rise !== 4'b0 || fall !== 4'b0 || any_change !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: do=%b r=%b f=%b any=%b, want do=0100 r=0000 f=0000 any=0",
               data_out, rise, fall, any_change);
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_do = (k >= 5) ? 4'hF : 4'b0100;
      exp_r  = (k == 5) ? 4'b1011 : 4'b0000;
      checks++;
      if (data_out !== exp_do || rise !== exp_r || fall !== 4'b0) begin
        errors++;
        $display("FAIL reset_release edge %0d: do=%b r=%b f=%b, want do=%b r=%b f=0000",
                 k, data_out, rise, fall, exp_do, exp_r);
      end
    end
  endtask

  task automatic test_latency();
    logic [3:0] exp_do, exp_r;
    do_reset(4'b0100);
    data_in = 4'b0101;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp_do = (k >= 5) ? 4'b0101 : 4'b0100;
      exp_r  = (k == 5) ? 4'b0001 : 4'b0000;
      checks++;
      if (data_out !== exp_do || rise !== exp_r || fall !== 4'b0 ||
          any_change !== (k == 5)) begin
        errors++;
        $display("FAIL latency edge %0d: do=%b r=%b f=%b any=%b, want do=%b r=%b f=0000 any=%b",
                 k, data_out, rise, fall, any_change, exp_do, exp_r, (k == 5));
      end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] exp_do, exp_r, exp_f;
    // Two sampled edges: must be swallowed.
    for (int k = 1; k <= 10; k++) begin
      data_in[1] = (k <= 2);
      tick();
      checks++;
      if (data_out !== 4'b0101 || rise !== 4'b0 || fall !== 4'b0 || any_change !== 1'b0) begin
        errors++;
        $display("FAIL glitch2 edge %0d: do=%b r=%b f=%b any=%b, want do=0101 quiet",
                 k, data_out, rise, fall, any_change);
      end
    end
    // Three sampled edges: passes, held high for three cycles, then falls.
    for (int k = 1; k <= 11; k++) begin
      data_in[1] = (k <= 3);
      tick();
      exp_do = (k >= 5 && k <= 7) ? 4'b0111 : 4'b0101;
      exp_r  = (k == 5) ? 4'b0010 : 4'b0000;
      exp_f  = (k == 8) ? 4'b0010 : 4'b0000;
      checks++;
      if (data_out !== exp_do || rise !== exp_r || fall !== exp_f ||
          any_change !== (k == 5 || k == 8)) begin
        errors++;
        $display("FAIL glitch3 edge %0d: do=%b r=%b f=%b any=%b, want do=%b r=%b f=%b",
                 k, data_out, rise, fall, any_change, exp_do, exp_r, exp_f);
      end
    end
  endtask

  task automatic test_mixed();
    logic [3:0] exp_do, exp_r, exp_f;
    data_in = 4'b1001;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_do = (k >= 5) ? 4'b1001 : 4'b0101;
      exp_r  = (k == 5) ? 4'b1000 : 4'b0000;
      exp_f  = (k == 5) ? 4'b0100 : 4'b0000;
      checks++;
      if (data_out !== exp_do || rise !== exp_r || fall !== exp_f ||
          any_change !== (k == 5)) begin
        errors++;
        $display("FAIL mixed edge %0d: do=%b r=%b f=%b any=%b, want do=%b r=%b f=%b any=%b",
                 k, data_out, rise, fall, any_change, exp_do, exp_r, exp_f, (k == 5));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_do, exp_r, exp_f;
    data_in = 4'b1000;
    repeat (8) tick();
    checks++;
    if (data_out !== 4'b1000) begin
      errors++;
      $display("FAIL mid_setup: do=%b, want 1000", data_out);
    end
    data_in = 4'b1001;
    repeat (3) tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (data_out !== 4'b0100 || rise !== 4'b0 || fall !== 4'b0 || any_change !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: do=%b r=%b f=%b any=%b, want do=0100 quiet",
               data_out, rise, fall, any_change);
    end
    tick();
    reset_n = 1'b1;
    checks++;
    if (data_out !== 4'b0100 || rise !== 4'b0 || fall !== 4'b0) begin
      errors++;
      $display("FAIL mid_reset_hold: do=%b r=%b f=%b, want do=0100 quiet", data_out, rise, fall);
    end
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_do = (k >= 5) ? 4'b1001 : 4'b0100;
      exp_r  = (k == 5) ? 4'b1001 : 4'b0000;
      exp_f  = (k == 5) ? 4'b0100 : 4'b0000;
      checks++;
      if (data_out !== exp_do || rise !== exp_r || fall !== exp_f ||
          any_change !== (k == 5)) begin
        errors++;
        $display("FAIL mid_relatency edge %0d: do=%b r=%b f=%b any=%b, want do=%b r=%b f=%b",
                 k, data_out, rise, fall, any_change, exp_do, exp_r, exp_f);
      end
    end
  endtask

  function automatic logic pat(input int j);
    if (j <= 0) return 1'b0;
    return (((j - 1) / 2) % 2) == 0;
  endfunction

  task automatic test_chatter();
    logic cur, prev;
    din2 = 4'b0100;
    repeat (6) tick();
    for (int k = 1; k <= 16; k++) begin
      din2[0] = pat(k);
      tick();
      cur  = pat(k - 3);
      prev = pat(k - 4);
      checks++;
      if (dout2 !== {3'b010, cur} || rise2 !== {3'b000, cur & ~prev} ||
          fall2 !== {3'b000, ~cur & prev} || any2 !== (cur ^ prev)) begin
        errors++;
        $display("FAIL chatter edge %0d: do=%b r=%b f=%b any=%b, want do=%b r=%b f=%b any=%b",
                 k, dout2, rise2, fall2, any2, {3'b010, cur}, {3'b000, cur & ~prev},
                 {3'b000, ~cur & prev}, cur ^ prev);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_mixed();
    test_reset_mid();
    test_chatter();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
